// File: rtl/spi_pkg.sv
// Shared constants for the SPI master/slave register map: addresses, status
// bit positions, slave FSM encodings and a status-byte packing helper.
package spi_pkg;

  localparam logic SPI_ADDR_CTL  = 1'b0;
  localparam logic SPI_ADDR_DATA = 1'b1;

  localparam int unsigned STAT_RXV   = 0;
  localparam int unsigned STAT_TXE   = 1;
  localparam int unsigned STAT_OVR   = 2;
  localparam int unsigned STAT_SEL   = 3;
  localparam int unsigned STAT_IRQEN = 4;
  localparam int unsigned STAT_BUSY  = 7;

  localparam logic [0:0] SLV_IDLE   = 1'b0;
  localparam logic [0:0] SLV_ACTIVE = 1'b1;

  typedef struct packed {
    logic busy;
    logic irq_en;
    logic selected;
    logic overrun;
    logic tx_empty;
    logic rx_valid;
  } spi_status_t;

  function automatic logic [7:0] spi_pack_status(input spi_status_t s);
    logic [7:0] r;
    r = 8'h00;
    r[STAT_RXV]   = s.rx_valid;
    r[STAT_TXE]   = s.tx_empty;
    r[STAT_OVR]   = s.overrun;
    r[STAT_SEL]   = s.selected;
    r[STAT_IRQEN] = s.irq_en;
    r[STAT_BUSY]  = s.busy;
    return r;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with an extra
// history flop producing single-cycle rise/fall pulses.
module spi_pin_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = i_pin;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q;
  assign o_rise  = sync_q & ~prev_q;
  assign o_fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder with single-buffered rx/tx and a 1-bit-address CPU port.
// Define SPI_SLAVE_OVR_EN to keep the old rx byte and flag overrun instead of overwriting.
module spi_slave
  import spi_pkg::*;
#(
  parameter bit IRQ_ON_OVR = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_addr,
  input  logic       i_cs,
  input  logic       i_we,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic       i_sck,
  input  logic       i_mosi,
  input  logic       i_ss,
  output logic       o_miso,
  output logic       o_irq
);

  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic ss_level, ss_rise, ss_fall;
  logic unused_pins;

  spi_pin_sync u_sync_sck (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_pin     (i_sck),
    .o_level   (sck_level),
    .o_rise    (sck_rise),
    .o_fall    (sck_fall)
  );

  spi_pin_sync u_sync_mosi (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_pin     (i_mosi),
    .o_level   (mosi_level),
    .o_rise    (mosi_rise),
    .o_fall    (mosi_fall)
  );

  spi_pin_sync u_sync_ss (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_pin     (i_ss),
    .o_level   (ss_level),
    .o_rise    (ss_rise),
    .o_fall    (ss_fall)
  );

  assign unused_pins = sck_level ^ mosi_rise ^ mosi_fall;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_empty_q, tx_empty_d;
  logic       overrun_q, overrun_d;
  logic       irq_en_q, irq_en_d;
  logic       skip_fall_q, skip_fall_d;

  logic       rd_data, wr_data, wr_ctl;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic [7:0] tx_load_val;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_buf_d    = rx_buf_q;
    tx_buf_d    = tx_buf_q;
    rx_valid_d  = rx_valid_q;
    tx_empty_d  = tx_empty_q;
    overrun_d   = overrun_q;
    irq_en_d    = irq_en_q;
    skip_fall_d = skip_fall_q;
    byte_done   = 1'b0;

    rd_data     = i_cs & ~i_we & (i_addr == SPI_ADDR_DATA);
    wr_data     = i_cs & i_we & (i_addr == SPI_ADDR_DATA);
    wr_ctl      = i_cs & i_we & (i_addr == SPI_ADDR_CTL);
    rx_byte     = {rx_sh_q[6:0], mosi_level};
    tx_load_val = tx_empty_q ? 8'h00 : tx_buf_q;

    if (rd_data) begin
      rx_valid_d = 1'b0;
    end
    if (wr_ctl) begin
      irq_en_d = i_dat[STAT_IRQEN];
      if (i_dat[STAT_OVR]) begin
        overrun_d = 1'b0;
      end
    end

    case (state_q)
      SLV_IDLE: begin
        bit_cnt_d   = 3'd0;
        skip_fall_d = 1'b0;
        if (ss_rise) begin
          state_d    = SLV_ACTIVE;
          tx_sh_d    = tx_load_val;
          tx_empty_d = 1'b1;
        end
      end
      SLV_ACTIVE: begin
        if (ss_fall) begin
          state_d     = SLV_IDLE;
          bit_cnt_d   = 3'd0;
          skip_fall_d = 1'b0;
        end else if (sck_rise) begin
          rx_sh_d = rx_byte;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d   = 3'd0;
            byte_done   = 1'b1;
            tx_sh_d     = tx_load_val;
            tx_empty_d  = 1'b1;
            skip_fall_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sck_fall) begin
          // The fall after a byte's last rise must not shift out the freshly reloaded MSB.
          if (skip_fall_q) begin
            skip_fall_d = 1'b0;
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = SLV_IDLE;
      end
    endcase

`ifdef SPI_SLAVE_OVR_EN
    if (byte_done) begin
      if (rx_valid_q && !rd_data) begin
        overrun_d = 1'b1;
      end else begin
        rx_buf_d   = rx_byte;
        rx_valid_d = 1'b1;
      end
    end
`else
    if (byte_done) begin
      rx_buf_d   = rx_byte;
      rx_valid_d = 1'b1;
    end
    overrun_d = 1'b0;
`endif

    // A CPU write in the reload cycle stays buffered for the next byte.
    if (wr_data) begin
      tx_buf_d   = i_dat;
      tx_empty_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= SLV_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 8'h00;
      tx_sh_q     <= 8'h00;
      rx_buf_q    <= 8'h00;
      tx_buf_q    <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_empty_q  <= 1'b1;
      overrun_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      skip_fall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_buf_q    <= rx_buf_d;
      tx_buf_q    <= tx_buf_d;
      rx_valid_q  <= rx_valid_d;
      tx_empty_q  <= tx_empty_d;
      overrun_q   <= overrun_d;
      irq_en_q    <= irq_en_d;
      skip_fall_q <= skip_fall_d;
    end
  end

  spi_status_t status;

  always_comb begin
    status.busy     = (bit_cnt_q != 3'd0);
    status.irq_en   = irq_en_q;
    status.selected = ss_level;
    status.overrun  = overrun_q;
    status.tx_empty = tx_empty_q;
    status.rx_valid = rx_valid_q;
    o_dat = (i_addr == SPI_ADDR_DATA) ? rx_buf_q : spi_pack_status(status);
  end

  assign o_miso = (state_q == SLV_ACTIVE) & tx_sh_q[7];
  assign o_irq  = irq_en_q & (rx_valid_q | (IRQ_ON_OVR & overrun_q));

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (mode 0, MSB first, 8-bit frames) with a CPU-side register port that matches the SPI master's register map. The block lets one board's CPU answer a master that uses the team's SPI master block. All SPI pins are oversampled in the `i_clk` domain, and each direction is single-buffered. It sits on the same 1-bit-address peripheral bus as the master and raises a level interrupt when a received byte is waiting.

## Interface
- `IRQ_ON_OVR`, default 1: when 1, a set overrun flag also drives `o_irq`.

Ports:
- `i_clk`, in, 1: system clock.
- `i_reset_n`, in, 1: one clock; reset is synchronous and active-low.
- `i_addr`, in, 1: 0 = ctl/status, 1 = rx/tx data.
- `i_cs`, in, 1: bus select.
- `i_we`, in, 1: write strobe, qualified by `i_cs`.
- `i_dat`, in, 8: write data.
- `o_dat`, out, 8: read data, combinational from `i_addr`.
- `i_sck`, in, 1: SPI clock, asynchronous.
- `i_mosi`, in, 1: SPI data in, asynchronous.
- `i_ss`, in, 1: select, active-high, asynchronous.
- `o_miso`, out, 1: SPI data out. Driven 0 while deselected; no tristate.
- `o_irq`, out, 1: level interrupt.

## Operation
Register map:
- Addr 0, read: bit0 `rx_valid`, bit1 `tx_empty`, bit2 `overrun`, bit3 `selected` (synchronised `i_ss`), bit4 `irq_en`, bit7 `busy` (bit count ≠ 0), others 0.
- Addr 0, write: bit4 → `irq_en`. bit2 = 1 clears `overrun`.
- Addr 1, read: returns the rx buffer. A read cycle (`i_cs && !i_we && i_addr`) clears `rx_valid`.
- Addr 1, write: loads the tx buffer and clears `tx_empty`.

SPI pins:
- `i_sck`, `i_mosi` and `i_ss` each pass through 2 flops plus an edge-detect flop.
- MOSI is delayed identically to SCK, so the sample matches the master's bit.

States:
- IDLE (`selected`=0):
  - Bit count 0; `o_miso` = 0.
  - On the synced `i_ss` rise → ACTIVE, loading the shift register from the tx buffer. If the tx buffer is empty, load 0x00.
  - Set `tx_empty`.
- ACTIVE, SCK rise:
  - Shift `{sh[6:0], mosi}` into the rx path; bit count +1.
  - At count 8: copy the assembled byte to the rx buffer, set `rx_valid`, reset the count to 0, and reload the tx shift register from the tx buffer (same empty rule).
- ACTIVE, SCK fall: shift the tx register left; `o_miso` = tx_sh[7].
- ACTIVE, synced `i_ss` fall → IDLE. A partial byte is discarded: `rx_valid` is unchanged and the tx byte is lost.
- `o_irq` = `irq_en & (rx_valid | (IRQ_ON_OVR & overrun))`.

## Timing
- Reset values:
  - `o_miso` = 0, `o_irq` = 0, `o_dat` reads 0x02 at addr 0.
  - `rx_valid` = 0, `tx_empty` = 1, `overrun` = 0, `irq_en` = 0, buffers 0x00, state IDLE.
- Reset mid-frame aborts the frame immediately.
- Pin-to-internal latency is 3 `i_clk` cycles.
- Master requirements:
  - SCK high and low phases each ≥ 2 `i_clk` cycles.
  - `i_ss` asserted ≥ 4 cycles before the first SCK rise.
- `rx_valid` rises 3 cycles after the 8th SCK rise; `o_irq` rises in the same cycle.
- Simultaneous rx-data read and byte completion: the new byte wins, `rx_valid` stays 1, no overrun.
- Simultaneous tx write and reload:
  - The shift register takes the old buffer content, or 0x00 if the buffer was empty.
  - The written byte stays buffered and `tx_empty` = 0.
- Simultaneous overrun set and clear: set wins.

## Configuration
- `SPI_SLAVE_OVR_EN` defined:
  - A byte completing while `rx_valid` = 1 sets `overrun`.
  - The rx buffer keeps the old byte; the new byte is dropped.
- `SPI_SLAVE_OVR_EN` undefined:
  - The new byte overwrites the rx buffer.
  - Status bit2 reads 0, and `IRQ_ON_OVR` has no effect.

## Structure
- Shared package `spi_pkg` holds:
  - Address constants `SPI_ADDR_CTL` = 0 and `SPI_ADDR_DATA` = 1.
  - Status bit indices (RXV = 0, TXE = 1, OVR = 2, SEL = 3, IRQEN = 4, BUSY = 7).
  - The master reuses the same constants.
- One sub-module, `spi_pin_sync`: 2-flop synchroniser plus rise/fall pulse outputs. It is instantiated three times, for SCK, MOSI and SS.

## Test plan
- **Basic exchange:** write tx 0xA5, assert SS, master clocks MOSI 0x3C at 4-clock SCK. Required: MISO bits read 0xA5; `rx_valid` = 1; addr 1 reads 0x3C; afterwards `rx_valid` = 0.
- **Empty tx:**
  - Two back-to-back bytes 0x11 and 0x22 with tx written once (0x5A). Required: MISO 0x5A then 0x00; `tx_empty` = 1 after the first load.
- **Overrun:** two bytes 0x01 and 0x02 with no CPU read.
  - With the macro: rx buffer = 0x01, `overrun` = 1, `o_irq` = 1 when `irq_en` = 1; writing 0x04 to addr 0 clears it.
  - Without the macro: rx buffer = 0x02.
- **Abort:** deassert SS after 5 SCK rises. Required: `busy` → 0, `rx_valid` stays 0; the next full frame 0xC3 is received correctly.
- **Simultaneous read:** CPU reads addr 1 in the exact cycle the second byte completes. Required: `rx_valid` = 1, `overrun` = 0.
- **Reset mid-frame:** `i_reset_n` = 0 after 3 bits. Required: all outputs and registers return to the reset values listed above.
